// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the accumulator CPU core:
// opcodes, sequencer states and flag bit positions.
package acc_cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_LD  = 4'h2;
    localparam logic [3:0] OP_ST  = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JZ  = 4'h5;
    localparam logic [3:0] OP_JC  = 4'h6;
    localparam logic [3:0] OP_OUT = 4'h7;
    localparam logic [3:0] OP_ADD = 4'h8;
    localparam logic [3:0] OP_SUB = 4'h9;
    localparam logic [3:0] OP_AND = 4'hA;
    localparam logic [3:0] OP_OR  = 4'hB;
    localparam logic [3:0] OP_XOR = 4'hC;
    localparam logic [3:0] OP_NOT = 4'hD;
    localparam logic [3:0] OP_SHL = 4'hE;
    localparam logic [3:0] OP_SHR = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2
    } state_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_ST) ||
               ((op >= OP_ADD) && (op <= OP_XOR));
    endfunction

endpackage

// File: rtl/acc_cpu_core_alu.sv
// Combinational ALU: result plus carry/zero for the accumulator ops.
// Any non-ALU opcode passes b through, which is how LD sets Z.
module alu_w
    import acc_cpu_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [3:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] result,
    output logic          c,
    output logic          z
);

    logic [DW:0] sum;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        result = b;
        c      = 1'b0;
        case (op)
            OP_ADD: {c, result} = sum;
            OP_SUB: begin
                result = a - b;
                c      = (a < b);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SHL: begin
                result = {a[DW-2:0], 1'b0};
                c      = a[DW-1];
            end
            OP_SHR: begin
                result = {1'b0, a[DW-1:1]};
                c      = a[0];
            end
            default: ;
        endcase
        z = (result == '0);
    end

endmodule

// File: rtl/acc_cpu_core.sv
// Accumulator CPU core: FETCH/EXEC/MEM sequencer with registered
// request strobes, IR, pc, acc, {C,Z} flags and the OUT register.
module acc_cpu_core
    import acc_cpu_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [AW-1:0]   imem_addr,
    input  logic            imem_ack,
    input  logic [AW+3:0]   imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [AW-1:0]   dmem_addr,
    output logic [DW-1:0]   dmem_wdata,
    input  logic            dmem_ack,
    input  logic [DW-1:0]   dmem_rdata,
    output logic [DW-1:0]   out_data,
    output logic            out_valid,
    output logic [AW-1:0]   dbg_pc,
    output logic [DW-1:0]   dbg_acc,
    output logic [1:0]      dbg_flags,
    output logic [1:0]      dbg_state
);

    localparam int IW = 4 + AW;

    state_t          state;
    logic [IW-1:0]   ir;
    logic [AW-1:0]   pc;
    logic [DW-1:0]   acc;
    logic [1:0]      flags;

    logic [3:0]      op;
    logic [AW-1:0]   arg;
    logic [DW-1:0]   imm;
    logic [DW-1:0]   alu_res;
    logic            alu_c;
    logic            alu_z;

    assign op  = ir[IW-1:AW];
    assign arg = ir[AW-1:0];
    assign imm = arg[DW-1:0];

    // Operand b is the memory word; only sampled when dmem_ack is high.
    alu_w #(.DW(DW)) u_alu (
        .op     (op),
        .a      (acc),
        .b      (dmem_rdata),
        .result (alu_res),
        .c      (alu_c),
        .z      (alu_z)
    );

    assign imem_addr  = pc;
    assign dmem_we    = dmem_req && (op == OP_ST);
    assign dmem_addr  = arg;
    assign dmem_wdata = acc;

    assign dbg_pc    = pc;
    assign dbg_acc   = acc;
    assign dbg_flags = flags;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_FETCH;
            ir        <= '0;
            pc        <= '0;
            acc       <= '0;
            flags     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            imem_req  <= 1'b0;
            dmem_req  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_FETCH: begin
                    imem_req <= 1'b1;
                    if (imem_req && imem_ack) begin
                        ir       <= imem_rdata;
                        pc       <= pc + AW'(1);
                        imem_req <= 1'b0;
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state    <= ST_FETCH;
                    imem_req <= 1'b1;
                    unique case (1'b1)
                        is_mem_op(op): begin
                            state    <= ST_MEM;
                            imem_req <= 1'b0;
                            dmem_req <= 1'b1;
                        end
                        op == OP_LDI: begin
                            acc           <= imm;
                            flags[FLAG_Z] <= (imm == '0);
                        end
                        op == OP_JMP: pc <= arg;
                        op == OP_JZ:
                            if (flags[FLAG_Z]) pc <= arg;
                        op == OP_JC:
                            if (flags[FLAG_C]) pc <= arg;
                        op == OP_OUT: begin
                            out_data  <= acc;
                            out_valid <= 1'b1;
                        end
                        op >= OP_NOT: begin
                            acc   <= alu_res;
                            flags <= {alu_c, alu_z};
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    if (dmem_req && dmem_ack) begin
                        dmem_req <= 1'b0;
                        imem_req <= 1'b1;
                        state    <= ST_FETCH;
                        if (op == OP_LD) begin
                            acc           <= dmem_rdata;
                            flags[FLAG_Z] <= alu_z;
                        end else if (op != OP_ST) begin
                            acc   <= alu_res;
                            flags <= {alu_c, alu_z};
                        end
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed bench for acc_cpu_core (DW=8, AW=12) with
// zero-wait instruction memory and a delay-programmable data memory.
module tb_acc_cpu_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [11:0] dmem_addr;
    logic [7:0]  dmem_wdata;
    logic        dmem_ack;
    logic [7:0]  dmem_rdata;
    logic [7:0]  out_data;
    logic        out_valid;
    logic [11:0] dbg_pc;
    logic [7:0]  dbg_acc;
    logic [1:0]  dbg_flags;
    logic [1:0]  dbg_state;

    logic [15:0] imem [0:4095];
    logic [7:0]  dmem [0:4095];
    int          dcnt = 0;
    int          dm_wait = 0;
    logic        force_ack = 1'b0;
    int          ov_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    acc_cpu_core #(.DW(8), .AW(12)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .dbg_pc     (dbg_pc),
        .dbg_acc    (dbg_acc),
        .dbg_flags  (dbg_flags),
        .dbg_state  (dbg_state)
    );

    assign imem_ack   = imem_req;
    assign imem_rdata = imem[imem_addr];
    assign dmem_rdata = dmem[dmem_addr];
    assign dmem_ack   = force_ack || (dmem_req && (dcnt >= dm_wait));

    always @(posedge clk) begin
        if (dmem_req && !dmem_ack) dcnt <= dcnt + 1;
        else dcnt <= 0;
        if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr] = dmem_wdata;
    end

    always @(negedge clk) if (out_valid) ov_cnt++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        force_ack = 1'b0;
        dm_wait   = 0;
        ov_cnt    = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4096; i++) imem[i] = 16'h0000;
    endtask

    task automatic wait_fetch(input logic [11:0] a, output int n);
        n = 0;
        while (!(imem_req && imem_addr == a) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL wait_fetch: timeout waiting for 0x%0h", a);
        end
    endtask

    initial begin
        int n;
        int cnt;
        logic stable;

        for (int i = 0; i < 4096; i++) dmem[i] = 8'h00;

        // LDI 0xFF; ADD 0x010 with mem=0x01; also reset values
        do_reset();
        imem[0] = 16'h10FF;
        imem[1] = 16'h8010;
        imem[2] = 16'h4002;
        dmem[12'h010] = 8'h01;
        check("rst_pc", dbg_pc, 0);
        check("rst_acc", dbg_acc, 0);
        check("rst_flags", dbg_flags, 0);
        check("rst_state", dbg_state, 0);
        check("rst_reqs", {imem_req, dmem_req, dmem_we, out_valid}, 0);
        check("rst_out", out_data, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_fetch", {imem_req, imem_addr}, {1'b1, 12'h000});
        wait_fetch(12'h002, n);
        check("add_cycles", n, 5);
        check("add_acc", dbg_acc, 8'h00);
        check("add_flags", dbg_flags, 2'b11);

        // LDI 0x05; SUB 0x020 (0x06); JZ not taken; JC taken
        do_reset();
        imem[0] = 16'h1005;
        imem[1] = 16'h9020;
        imem[2] = 16'h5200;
        imem[3] = 16'h6100;
        imem[12'h100] = 16'h4100;
        dmem[12'h020] = 8'h06;
        rst_n = 1'b1;
        wait_fetch(12'h002, n);
        check("sub_acc", dbg_acc, 8'hFF);
        check("sub_flags", dbg_flags, 2'b10);
        wait_fetch(12'h003, n);
        check("jz_not_taken", n, 2);
        wait_fetch(12'h100, n);
        check("jc_taken", n, 2);

        // LDI 0x5A; ST 0x030 with 3-cycle ack delay
        do_reset();
        imem[0] = 16'h105A;
        imem[1] = 16'h3030;
        imem[2] = 16'h4002;
        dm_wait = 3;
        rst_n = 1'b1;
        wait_fetch(12'h001, n);
        cnt = 0;
        while (!dmem_req && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        cnt = 0;
        stable = 1'b1;
        while (dmem_req && cnt < 20) begin
            if (dmem_addr != 12'h030 || !dmem_we || dmem_wdata != 8'h5A)
                stable = 1'b0;
            cnt++;
            @(negedge clk);
        end
        check("st_req_cycles", cnt, 4);
        check("st_stable", stable, 1);
        wait_fetch(12'h002, n);
        check("st_mem", dmem[12'h030], 8'h5A);
        check("st_acc", dbg_acc, 8'h5A);
        check("st_flags", dbg_flags, 2'b00);

        // LDI 0x81; SHL; OUT
        do_reset();
        imem[0] = 16'h1081;
        imem[1] = 16'hE000;
        imem[2] = 16'h7000;
        imem[3] = 16'h4003;
        rst_n = 1'b1;
        wait_fetch(12'h003, n);
        repeat (3) @(negedge clk);
        check("out_strobes", ov_cnt, 1);
        check("out_data", out_data, 8'h02);
        check("shl_acc", dbg_acc, 8'h02);
        check("shl_flags", dbg_flags, 2'b10);

        // LDI 0xF0; XOR 0x050 (0xFF); NOT; SHR
        do_reset();
        imem[0] = 16'h10F0;
        imem[1] = 16'hC050;
        imem[2] = 16'hD000;
        imem[3] = 16'hF000;
        imem[4] = 16'h4004;
        dmem[12'h050] = 8'hFF;
        rst_n = 1'b1;
        wait_fetch(12'h002, n);
        check("xor_acc", dbg_acc, 8'h0F);
        wait_fetch(12'h003, n);
        check("not_acc", dbg_acc, 8'hF0);
        wait_fetch(12'h004, n);
        check("shr_acc", dbg_acc, 8'h78);
        check("shr_flags", dbg_flags, 2'b00);

        // JMP 0xFFF; NOP at 0xFFF wraps pc to 0
        do_reset();
        imem[0] = 16'h4FFF;
        rst_n = 1'b1;
        wait_fetch(12'hFFF, n);
        wait_fetch(12'h000, n);
        check("pc_wrap", n, 2);

        // Reset mid-MEM with ack pending, stray ack afterwards
        do_reset();
        imem[0] = 16'h103C;
        imem[1] = 16'h2040;
        imem[2] = 16'h4002;
        dmem[12'h040] = 8'h77;
        dm_wait = 100;
        rst_n = 1'b1;
        cnt = 0;
        while (!dmem_req && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        repeat (2) @(negedge clk);
        check("mid_mem_state", dbg_state, 2);
        check("mid_mem_acc", dbg_acc, 8'h3C);
        rst_n = 1'b0;
        force_ack = 1'b1;
        repeat (2) @(negedge clk);
        check("mrst_pc", dbg_pc, 0);
        check("mrst_acc", dbg_acc, 0);
        check("mrst_flags", dbg_flags, 0);
        check("mrst_reqs", {imem_req, dmem_req, dmem_we}, 0);
        dm_wait = 0;
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_fetch", {imem_req, imem_addr}, {1'b1, 12'h000});
        check("stray_ack_acc", dbg_acc, 0);
        check("stray_ack_state", dbg_state, 0);
        force_ack = 1'b0;
        wait_fetch(12'h002, n);
        check("ld_acc", dbg_acc, 8'h77);
        check("ld_flags", dbg_flags, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/acc_cpu_core.md
ACC_CPU_CORE -- requirements
Module: acc_cpu_core

Interface
REQ-001 Parameter DW, default 8, accumulator/data width (4..32).
REQ-002 Parameter AW, default 12, address width (DW<=AW<=16); instruction width IW=4+AW.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 imem_req/imem_addr/imem_ack/imem_rdata  out/out/in/in  1/AW/1/IW  instruction fetch port.
REQ-006 dmem_req/dmem_we/dmem_addr/dmem_wdata  out/out/out/out  1/1/AW/DW  data port request.
REQ-007 dmem_ack/dmem_rdata  in/in  1/DW  data port completion.
REQ-008 out_data/out_valid  out/out  DW/1  OUT-port register; one-cycle strobe.
REQ-009 dbg_pc/dbg_acc/dbg_flags/dbg_state  out  AW/DW/2 {C,Z}/2  debug taps.

Function
REQ-010 Instruction = {op[3:0], arg[AW-1:0]}; immediate = arg[DW-1:0].
REQ-011 Opcodes: 0 NOP, 1 LDI, 2 LD, 3 ST, 4 JMP, 5 JZ, 6 JC, 7 OUT; 8 ADD, 9 SUB, 10 AND, 11 OR, 12 XOR, 13 NOT, 14 SHL, 15 SHR.
REQ-012 ALU ops 8-12 use operand mem[arg]; 13-15 act on acc only, no memory access.
REQ-013 States: FETCH, EXEC, MEM; no other reachable state.
REQ-014 FETCH: imem_req=1, imem_addr=pc; on imem_ack latch IR, pc<=pc+1 mod 2^AW, go EXEC.
REQ-015 EXEC: NOP/LDI/JMP/JZ/JC/OUT/13-15 complete and return to FETCH; LD/ST/8-12 go MEM.
REQ-016 MEM: dmem_req=1, dmem_addr=arg, dmem_we=1 only for ST, dmem_wdata=acc; on dmem_ack complete, go FETCH.
REQ-017 Request held with stable addr/we/wdata until ack sampled high; ack in first req cycle legal; req deasserted cycle after ack.
REQ-018 rdata sampled only in ack cycle; ack while req low ignored.
REQ-019 Throughput with zero-wait memory: 2 cycles non-memory op, 3 cycles memory op.
REQ-020 JMP: pc<=arg. JZ/JC: pc<=arg iff Z/C set, else pc unchanged.
REQ-021 ADD: {C,acc}=acc+op; SUB: acc=acc-op, C=1 on borrow (acc<op); SHL: C=acc[DW-1]; SHR: C=acc[0]; AND/OR/XOR/NOT: C=0.
REQ-022 Z=(result==0) for ALU ops, LD, LDI; LDI/LD leave C unchanged; other ops leave flags unchanged.
REQ-023 OUT: out_data<=acc, out_valid=1 for exactly one cycle; out_data holds until next OUT.
REQ-024 All arithmetic modulo 2^DW; pc wraps 2^AW-1 -> 0.

Reset
REQ-025 rst_n low at a clock edge, any state: state=FETCH, pc=0, acc=0, flags=00, IR=0, out_data=0.
REQ-026 During reset all req/we/out_valid outputs are 0; imem_req rises in first cycle after rst_n high.
REQ-027 Reset mid-MEM abandons transaction; late ack after reset is ignored, no acc/flag/pc change.

Structure
REQ-028 Shared package acc_cpu_pkg: opcode constants, state encoding, flag bit indices.
REQ-029 One sub-module alu_w (parametrised DW, combinational): op, a, b -> result, C, Z.
REQ-030 Sequencer, IR, pc, acc, flags and OUT register live in acc_cpu_core.

Verification (DW=8, AW=12)
REQ-031 rst_n low 2 cycles during MEM with dmem_ack pending -> dbg_pc=0x000, acc=0x00, flags=00, no req; fetch of 0x000 next cycle, stray ack ignored.
REQ-032 LDI 0xFF; ADD 0x010 (mem=0x01) -> acc=0x00, C=1, Z=1; zero-wait total 5 cycles.
REQ-033 LDI 0x05; SUB 0x020 (mem=0x06) -> acc=0xFF, C=1, Z=0; then JC 0x100 -> next imem_addr=0x100; JZ 0x200 not taken.
REQ-034 LDI 0x5A; ST 0x030 with dmem_ack delayed 3 cycles -> dmem_req held 4 cycles, addr=0x030, wdata=0x5A, we=1 stable; acc unchanged.
REQ-035 LDI 0x81; SHL; OUT -> acc=0x02, C=1, out_data=0x02, out_valid high exactly one cycle.
REQ-036 JMP 0xFFF; NOP at 0xFFF -> following fetch imem_addr=0x000.
